// File: rtl/mult_sequencer_pkg.sv
// rtl/mult_sequencer_pkg.sv - shared widths and FSM state encoding for the MULT sequencer
package mult_sequencer_pkg;

  localparam int MS_WORD_LEN  = 32;
  localparam int MULT_CNT_LEN = 6;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - EX-stage MULT request / stall / result bundle
interface mult_sequencer_if #(
  parameter int WORD_LEN = 32
);

  logic                start;
  logic                flush;
  logic [WORD_LEN-1:0] op_a;
  logic [WORD_LEN-1:0] op_b;
  logic                stall;
  logic                done;
  logic [WORD_LEN-1:0] result_lo;
  logic [WORD_LEN-1:0] result_hi;

  // EX stage side: issues the operation and honours the stall
  modport master (
    output start, flush, op_a, op_b,
    input  stall, done, result_lo, result_hi
  );

  // Sequencer side
  modport slave (
    input  start, flush, op_a, op_b,
    output stall, done, result_lo, result_hi
  );

endinterface

// File: rtl/mult_shift_add_step.sv
// rtl/mult_shift_add_step.sv - one combinational radix-2 shift-add iteration
module mult_shift_add_step
  import mult_sequencer_pkg::*;
#(
  parameter int WORD_LEN = MS_WORD_LEN
) (
  input  logic [2*WORD_LEN-1:0] acc,
  input  logic [2*WORD_LEN-1:0] mcand,
  input  logic [WORD_LEN-1:0]   mplier,
  output logic [2*WORD_LEN-1:0] acc_next,
  output logic [2*WORD_LEN-1:0] mcand_next,
  output logic [WORD_LEN-1:0]   mplier_next
);

  // Add the shifted multiplicand when the current multiplier bit is set; carry out is dropped
  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - multi-cycle signed MULT controller (optional MULT_SEQ_EARLY_TERM_EN)
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WORD_LEN = MS_WORD_LEN,
  parameter int CNT_LEN  = MULT_CNT_LEN
) (
  input  logic                clk,
  input  logic                rst,
  mult_sequencer_if.slave     bus
);

  ms_state_e               state;
  logic [2*WORD_LEN-1:0]   acc;
  logic [2*WORD_LEN-1:0]   mcand;
  logic [WORD_LEN-1:0]     mplier;
  logic [CNT_LEN-1:0]      cnt;
  logic                    neg;
  logic                    done_q;
  logic [WORD_LEN-1:0]     res_lo;
  logic [WORD_LEN-1:0]     res_hi;

  logic [2*WORD_LEN-1:0]   acc_nx;
  logic [2*WORD_LEN-1:0]   mcand_nx;
  logic [WORD_LEN-1:0]     mplier_nx;
  logic [WORD_LEN-1:0]     abs_a;
  logic [WORD_LEN-1:0]     abs_b;
  logic [2*WORD_LEN-1:0]   product;
  logic                    last;
  logic                    accept;

  mult_shift_add_step #(.WORD_LEN(WORD_LEN)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_nx),
    .mcand_next  (mcand_nx),
    .mplier_next (mplier_nx)
  );

  // Magnitudes are kept unsigned so |most negative| stays exact; sign is re-applied at the end
  always_comb begin
    abs_a   = bus.op_a[WORD_LEN-1] ? (~bus.op_a + WORD_LEN'(1)) : bus.op_a;
    abs_b   = bus.op_b[WORD_LEN-1] ? (~bus.op_b + WORD_LEN'(1)) : bus.op_b;
    product = neg ? -acc_nx : acc_nx;
    accept  = (state != MS_RUN) && bus.start && !bus.flush;
    last    = (cnt == CNT_LEN'(WORD_LEN - 1));
`ifdef MULT_SEQ_EARLY_TERM_EN
    last    = last || (mplier_nx == '0);
`endif
  end

  // Stall must rise in the very cycle the MULT is accepted, so it cannot be registered
  assign bus.stall     = (state == MS_RUN) || accept;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;

  // Sequencer FSM: latch operands, iterate, present the signed product for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MS_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MS_IDLE, MS_DONE: begin
          if (accept) begin
            mcand  <= {{WORD_LEN{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= bus.op_a[WORD_LEN-1] ^ bus.op_b[WORD_LEN-1];
            acc    <= '0;
            cnt    <= '0;
            state  <= MS_RUN;
          end else begin
            state  <= MS_IDLE;
          end
        end
        MS_RUN: begin
          if (bus.flush) begin
            state <= MS_IDLE;
          end else begin
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            cnt    <= cnt + CNT_LEN'(1);
            if (last) begin
              state  <= MS_DONE;
              done_q <= 1'b1;
              res_lo <= product[WORD_LEN-1:0];
              res_hi <= product[2*WORD_LEN-1:WORD_LEN];
            end
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer
module tb_mult_sequencer;
  import mult_sequencer_pkg::*;

  localparam int W = MS_WORD_LEN;

`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam int LAT_NEG3_5   = 4;
  localparam int LAT_MIN_MIN  = 33;
  localparam int LAT_M1_M1    = 2;
  localparam int LAT_B_ZERO   = 2;
  localparam int LAT_7_5      = 4;
  localparam int LAT_B2B_2ND  = 3;
`else
  localparam int LAT_NEG3_5   = 33;
  localparam int LAT_MIN_MIN  = 33;
  localparam int LAT_M1_M1    = 33;
  localparam int LAT_B_ZERO   = 33;
  localparam int LAT_7_5      = 33;
  localparam int LAT_B2B_2ND  = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mult_sequencer_if #(.WORD_LEN(W)) bus();

  mult_sequencer #(.WORD_LEN(W), .CNT_LEN(MULT_CNT_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arithmetic: plain signed 64-bit multiply
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Number of iterations the sequencer spends on a given multiplier
  function automatic int run_len(input logic [31:0] b);
    longint m;
    int     n;
    m = longint'($signed(b));
    if (m < 0) m = -m;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >>> 1;
    end
    if (n == 0) n = 1;
`ifdef MULT_SEQ_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? W : W;
`endif
  endfunction

  // Model: cycles of work outstanding, pending product and the result that should be on display
  int          run_left = 0;
  bit          exp_done = 1'b0;
  logic [63:0] exp_res  = '0;
  logic [63:0] pend_res = '0;

  // Compare on the falling edge, then advance the model as the next rising edge will
  always @(negedge clk) begin
    chk("stall", 64'(bus.stall), 64'((run_left > 0) || (bus.start && !bus.flush)));
    chk("done", 64'(bus.done), 64'(exp_done));
    chk("result", {bus.result_hi, bus.result_lo}, exp_res);
    if (rst) begin
      run_left = 0;
      exp_done = 1'b0;
      exp_res  = '0;
    end else begin
      exp_done = 1'b0;
      if (run_left > 0) begin
        if (bus.flush) begin
          run_left = 0;
        end else begin
          run_left--;
          if (run_left == 0) begin
            exp_done = 1'b1;
            exp_res  = pend_res;
          end
        end
      end else if (bus.start && !bus.flush) begin
        pend_res = ref_prod(bus.op_a, bus.op_b);
        run_left = run_len(bus.op_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MULT in the current cycle, hold start while stalled, return in the done cycle
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int lat);
    int s;
    s = cyc;
    lat = -1;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_done) begin
        lat = cyc - s;
        break;
      end
    end
    bus.start = 1'b0;
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int dcnt;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_result", {bus.result_hi, bus.result_lo}, 64'd0);
    tick();

    run_mult(32'hFFFF_FFFD, 32'd5, lat);
    chk("lat_neg3x5", 64'(lat), 64'(LAT_NEG3_5));
    chk("done_neg3x5", 64'(bus.done), 64'd1);
    chk("res_neg3x5", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    chk("idle_after_done", 64'(bus.stall), 64'd0);

    run_mult(32'h8000_0000, 32'h8000_0000, lat);
    chk("lat_minmin", 64'(lat), 64'(LAT_MIN_MIN));
    chk("res_minmin", {bus.result_hi, bus.result_lo}, 64'h4000_0000_0000_0000);
    tick();

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("lat_m1m1", 64'(lat), 64'(LAT_M1_M1));
    chk("res_m1m1", {bus.result_hi, bus.result_lo}, 64'h0000_0000_0000_0001);
    tick();

    run_mult(32'd7, 32'd0, lat);
    chk("lat_bzero", 64'(lat), 64'(LAT_B_ZERO));
    chk("res_bzero", {bus.result_hi, bus.result_lo}, 64'd0);
    tick();

    // Back-to-back: next MULT presented in the DONE cycle of the previous one
    run_mult(32'd7, 32'd5, lat);
    chk("lat_7x5", 64'(lat), 64'(LAT_7_5));
    chk("res_7x5", {bus.result_hi, bus.result_lo}, 64'd35);
    bus.start = 1'b1;
    bus.op_a  = 32'h1234_5678;
    bus.op_b  = 32'hFFFF_FFFE;
    #1;
    chk("b2b_stall", 64'(bus.stall), 64'd1);
    chk("b2b_done", 64'(bus.done), 64'd1);
    run_mult(32'h1234_5678, 32'hFFFF_FFFE, lat);
    chk("lat_b2b", 64'(lat), 64'(LAT_B2B_2ND));
    chk("res_b2b", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_DB97_5310);
    tick();

    // Flush in cycle 10 of a long multiply
    bus.start = 1'b1;
    bus.op_a  = 32'd3;
    bus.op_b  = 32'h7FFF_FFFF;
    repeat (10) tick();
    bus.flush = 1'b1;
    #1;
    chk("flush_cycle_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("after_flush_stall", 64'(bus.stall), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_res_kept", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_DB97_5310);

    // Flush and start together in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_start_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush_start_idle", 64'(bus.stall), 64'd0);
    chk("flush_start_done", 64'(bus.done), 64'd0);

    // Reset held two cycles in the middle of a run
    bus.start = 1'b1;
    bus.op_a  = 32'd9;
    bus.op_b  = 32'h7FFF_0000;
    repeat (5) tick();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_run_stall", 64'(bus.stall), 64'd0);
    chk("rst_run_done", 64'(bus.done), 64'd0);
    chk("rst_run_result", {bus.result_hi, bus.result_lo}, 64'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
